// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: funct codes and the multiply/divide state encoding.
package mips_pkg;

  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix.
  function automatic logic is_muldiv(input logic [5:0] fn);
    return fn[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU for the R-type register codes.
// Purely combinational, no flow control; unknown codes yield zero.
module alu
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [5:0]   i_ctrl,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result
);

  localparam int SW = $clog2(W);

  logic [SW-1:0] sh;
  assign sh = i_a[SW-1:0];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      FN_ADD, FN_ADDU: o_result = i_a + i_b;
      FN_SUB, FN_SUBU: o_result = i_a - i_b;
      FN_AND:          o_result = i_a & i_b;
      FN_OR:           o_result = i_a | i_b;
      FN_XOR:          o_result = i_a ^ i_b;
      FN_NOR:          o_result = ~(i_a | i_b);
      FN_SLT:          o_result = {{(W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      FN_SLTU:         o_result = {{(W-1){1'b0}}, i_a < i_b};
      FN_SLLV:         o_result = i_b << sh;
      FN_SRLV:         o_result = i_b >> sh;
      FN_SRAV:         o_result = W'($signed(i_b) >>> sh);
      default:         o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage arithmetic: single-cycle alu plus iterative radix-2 mul/div with HI/LO.
// Mul/div occupies W+1 cycles after issue; o_busy stalls the pipe, issue while busy is dropped.
module alu_muldiv
  import mips_pkg::*;
#(
  parameter int IO_BUS_WIDTH   = 32,
  parameter int CTRL_BUS_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CTRL_BUS_WIDTH-1:0] i_ctrl,
  input  logic                      i_start,
  input  logic                      i_flush,
  input  logic [IO_BUS_WIDTH-1:0]   i_data_A,
  input  logic [IO_BUS_WIDTH-1:0]   i_data_B,
  output logic [IO_BUS_WIDTH-1:0]   o_result,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [IO_BUS_WIDTH-1:0]   o_hi,
  output logic [IO_BUS_WIDTH-1:0]   o_lo
);

  localparam int W = IO_BUS_WIDTH;

  muldiv_state_t  state;
  logic [W-1:0]   cnt, dvsr, hi, lo;
  logic [2*W-1:0] acc;
  logic           is_div, neg_q, neg_r, div_zero;

  logic [5:0]   fn;
  logic         md_op, op_signed, sign_a, sign_b;
  logic [W-1:0] a_mag, b_mag, alu_res;

  assign fn        = 6'(i_ctrl);
  assign md_op     = is_muldiv(fn);
  assign op_signed = ~fn[0];
  assign sign_a    = op_signed & i_data_A[W-1];
  assign sign_b    = op_signed & i_data_B[W-1];
  assign a_mag     = sign_a ? -i_data_A : i_data_A;
  assign b_mag     = sign_b ? -i_data_B : i_data_B;

  alu #(.W(W)) u_alu (
    .i_ctrl   (fn),
    .i_a      (i_data_A),
    .i_b      (i_data_B),
    .o_result (alu_res)
  );

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  logic [W:0]     mul_sum, div_r, div_diff;
  logic           div_ge;
  logic [2*W-1:0] step_acc;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? dvsr : '0)};
    div_r    = {acc[2*W-1:W], acc[W-1]};
    div_diff = div_r - {1'b0, dvsr};
    div_ge   = div_r >= {1'b0, dvsr};
    if (is_div)
      step_acc = {(div_ge ? div_diff[W-1:0] : div_r[W-1:0]), acc[W-2:0], div_ge};
    else
      step_acc = {mul_sum, acc[W-1:1]};
  end

  // A zero divisor makes every quotient bit 1 and leaves |dividend| as remainder,
  // so only LO needs forcing; the remainder sign fix restores the original dividend.
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod   = neg_q ? -acc : acc;
    fix_hi = prod[2*W-1:W];
    fix_lo = prod[W-1:0];
    if (is_div) begin
      fix_hi = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
      fix_lo = div_zero ? '1 : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvsr     <= '0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_flush && i_start) begin
            if (md_op) begin
              acc      <= {{W{1'b0}}, a_mag};
              dvsr     <= b_mag;
              cnt      <= W'(W);
              is_div   <= fn[1];
              neg_q    <= sign_a ^ sign_b;
              neg_r    <= sign_a;
              div_zero <= (i_data_B == '0);
              state    <= CALC;
            end else if (fn == FN_MTHI) begin
              hi <= i_data_A;
            end else if (fn == FN_MTLO) begin
              lo <= i_data_A;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state <= IDLE;
          end else begin
            acc <= step_acc;
            cnt <= cnt - 1'b1;
            if (cnt == W'(1)) state <= FIX;
          end
        end
        FIX: begin
          if (!i_flush) begin
            hi     <= fix_hi;
            lo     <= fix_lo;
            o_done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);
  assign o_hi   = hi;
  assign o_lo   = lo;

  always_comb begin
    o_result = '0;
    if (fn == FN_MFHI)
      o_result = hi;
    else if (fn == FN_MFLO)
      o_result = lo;
    else if (!md_op && fn != FN_MTHI && fn != FN_MTLO)
      o_result = alu_res;
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: expected HI/LO queued at issue, checked when o_done fires.
module tb_alu_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   ctrl = FN_ADDU;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] da = '0;
  logic [W-1:0] db = '0;
  logic [W-1:0] result, hi, lo;
  logic         busy, done;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  always #5 clk = ~clk;

  alu_muldiv #(.IO_BUS_WIDTH(W), .CTRL_BUS_WIDTH(6)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_ctrl   (ctrl),
    .i_start  (start),
    .i_flush  (flush),
    .i_data_A (da),
    .i_data_B (db),
    .o_result (result),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Monitor: every o_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, want no done", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_hi", hi, mon_e[2*W-1:W]);
        chk("done_lo", lo, mon_e[W-1:0]);
      end
    end
  end

  task automatic issue(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    ctrl  = c;
    da    = a;
    db    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ctrl  = FN_ADDU;
  endtask

  // Issue, count busy cycles (optionally poking a MULT issue mid-flight), check pulse and MF*.
  task automatic run_op(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input int inject);
    int n;
    exp_q.push_back({ehi, elo});
    issue(c, a, b);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == inject) begin
        ctrl = FN_MULT; da = 32'h0000_0003; db = 32'h0000_0009; start = 1'b1;
      end else if (n == inject + 1) begin
        start = 1'b0; ctrl = FN_ADDU;
      end
    end
    chk("busy_cycles", 32'(n), 32'd33);
    chk("done_high", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    ctrl = FN_MFHI; #1;
    chk("mfhi_after_done", result, ehi);
    ctrl = FN_MFLO; #1;
    chk("mflo_after_done", result, elo);
    ctrl = FN_ADDU;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(FN_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, -5);
    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -5);
    run_op(FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -5);
    run_op(FN_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, -5);
    run_op(FN_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -5);
    run_op(FN_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, -5);
    run_op(FN_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, -5);
    run_op(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -5);
    run_op(FN_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        10);

    // Flush part-way through a second divide: HI/LO keep 2/14, no done.
    d0 = done_seen;
    issue(FN_DIVU, 32'd200, 32'd3);
    repeat (5) @(negedge clk);
    chk("busy_before_flush", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("busy_after_flush", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    chk("flush_no_done", 32'(done_seen - d0), 32'd0);

    // Flush in IDLE wins over a simultaneous MTHI.
    @(posedge clk);
    #1;
    ctrl = FN_MTHI; da = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_hi", hi, 32'd2);

    issue(FN_MTHI, 32'h0000_1234, 32'd0);
    chk("mthi", hi, 32'h0000_1234);
    issue(FN_MTLO, 32'h0000_5678, 32'd0);
    chk("mtlo", lo, 32'h0000_5678);
    ctrl = FN_MFHI; #1;
    chk("mfhi", result, 32'h0000_1234);
    ctrl = FN_MFLO; #1;
    chk("mflo", result, 32'h0000_5678);

    ctrl = FN_ADDU; da = 32'd5; db = 32'd7; #1;
    chk("addu", result, 32'd12);
    ctrl = FN_SUBU; #1;
    chk("subu", result, 32'hFFFF_FFFE);
    ctrl = FN_SLT; da = 32'hFFFF_FFFF; db = 32'd1; #1;
    chk("slt", result, 32'd1);
    ctrl = FN_SLTU; #1;
    chk("sltu", result, 32'd0);
    ctrl = 6'b111111; #1;
    chk("unknown_code", result, 32'd0);
    ctrl = FN_MULT; #1;
    chk("mult_code_result", result, 32'd0);
    ctrl = FN_ADDU;

    // Asynchronous reset mid-CALC clears state without a clock edge.
    issue(FN_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
